display_scan_controller: RTL

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

---
 rtl/display_pkg.sv | 40 ++++
 rtl/seg7_decoder.sv | 33 +++
 rtl/display_scan_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types, digit-select patterns, glyph table and the double-dabble step
// used by the 4-digit seven-segment scan controller.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    localparam logic [3:0] SEL_UNITS     = 4'b1110;
    localparam logic [3:0] SEL_TENS      = 4'b1101;
    localparam logic [3:0] SEL_HUNDREDS  = 4'b1011;
    localparam logic [3:0] SEL_THOUSANDS = 4'b0111;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} glyphs for decimal digits 0..9
    localparam logic [6:0] GLYPHS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [3:0] LAST_ITER = 4'd11;

    // One double-dabble iteration on {bcd[15:0], bin[11:0]}
    function automatic logic [27:0] dabble_step(input logic [27:0] v);
        logic [27:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[12+4*i +: 4] >= 4'd5) begin
                t[12+4*i +: 4] = t[12+4*i +: 4] + 4'd3;
            end else begin
                t[12+4*i +: 4] = t[12+4*i +: 4];
            end
        end
        return {t[26:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking;
// non-decimal codes are shown blank.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] segments
);

    // Glyph lookup, blank overrides the digit
    always_comb begin
        segments = SEG_BLANK;
        if (blank) begin
            segments = SEG_BLANK;
        end else begin
            case (digit)
                4'd0:    segments = GLYPHS[0];
                4'd1:    segments = GLYPHS[1];
                4'd2:    segments = GLYPHS[2];
                4'd3:    segments = GLYPHS[3];
                4'd4:    segments = GLYPHS[4];
                4'd5:    segments = GLYPHS[5];
                4'd6:    segments = GLYPHS[6];
                4'd7:    segments = GLYPHS[7];
                4'd8:    segments = GLYPHS[8];
                4'd9:    segments = GLYPHS[9];
                default: segments = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Accepts a 12-bit binary value, converts it to BCD by double-dabble and
// multiplexes the four digits onto a common-anode seven-segment display.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] value_in,
    input  logic        value_valid,
    output logic        value_ready,
    output logic        busy,
    output logic [6:0]  segments,
    output logic [3:0]  display_select
);

    localparam int               CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_e           state_r;
    state_e           state_s;
    logic [3:0]       iter_r;
    logic [27:0]      dd_r;
    logic [15:0]      display_r;
    logic [15:0]      display_s;
    logic [CNT_W-1:0] scan_cnt_r;
    logic [CNT_W-1:0] scan_next_s;
    logic [1:0]       digit_idx_r;
    logic [1:0]       digit_next_s;
    logic             accept_s;
    logic             ready_s;
    logic             busy_s;
    logic             ready_r;
    logic             busy_r;
    logic [3:0]       digit_s;
    logic             lead_blank_s;
    logic             blank_s;
    logic [3:0]       sel_s;
    logic [6:0]       dec_seg_s;
    logic [6:0]       segments_r;
    logic [3:0]       select_r;

    assign accept_s = value_valid && ready_r;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; COMMIT may take the next value so back-to-back values
    // are accepted every 13 cycles
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:    state_s = accept_s ? ST_CONVERT : ST_IDLE;
            ST_CONVERT: state_s = (iter_r == LAST_ITER) ? ST_COMMIT : ST_CONVERT;
            ST_COMMIT:  state_s = accept_s ? ST_CONVERT : ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they can be registered
    always_comb begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
        if (state_s == ST_CONVERT) begin
            ready_s = 1'b0;
            busy_s  = 1'b1;
        end else begin
            ready_s = 1'b1;
            busy_s  = 1'b0;
        end
    end

    // Handshake output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            ready_r <= ready_s;
            busy_r  <= busy_s;
        end
    end

    // Double-dabble datapath and display register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dd_r      <= 28'd0;
            iter_r    <= 4'd0;
            display_r <= 16'd0;
        end else begin
            if (accept_s) begin
                dd_r   <= {16'd0, value_in};
                iter_r <= 4'd0;
            end else if (state_r == ST_CONVERT) begin
                dd_r   <= dabble_step(dd_r);
                iter_r <= iter_r + 4'd1;
            end else begin
                dd_r   <= dd_r;
                iter_r <= iter_r;
            end
            display_r <= display_s;
        end
    end

    // Next-cycle scan position and display contents feed the output registers
    always_comb begin
        display_s    = (state_r == ST_COMMIT) ? dd_r[27:12] : display_r;
        scan_next_s  = (scan_cnt_r == CNT_MAX) ? CNT_ZERO : scan_cnt_r + CNT_ONE;
        digit_next_s = (scan_cnt_r == CNT_MAX) ? digit_idx_r + 2'd1 : digit_idx_r;
        digit_s      = display_s[3:0];
        lead_blank_s = 1'b0;
        sel_s        = SEL_UNITS;
        case (digit_next_s)
            2'd0: begin
                digit_s      = display_s[3:0];
                lead_blank_s = 1'b0;
                sel_s        = SEL_UNITS;
            end
            2'd1: begin
                digit_s      = display_s[7:4];
                lead_blank_s = (display_s[15:4] == 12'd0);
                sel_s        = SEL_TENS;
            end
            2'd2: begin
                digit_s      = display_s[11:8];
                lead_blank_s = (display_s[15:8] == 8'd0);
                sel_s        = SEL_HUNDREDS;
            end
            2'd3: begin
                digit_s      = display_s[15:12];
                lead_blank_s = (display_s[15:12] == 4'd0);
                sel_s        = SEL_THOUSANDS;
            end
            default: begin
                digit_s      = display_s[3:0];
                lead_blank_s = 1'b0;
                sel_s        = SEL_UNITS;
            end
        endcase
        blank_s = (scan_next_s == CNT_ZERO) || ((BLANK_LEADING != 0) && lead_blank_s);
    end

    seg7_decoder u_seg7_decoder (
        .digit    (digit_s),
        .blank    (blank_s),
        .segments (dec_seg_s)
    );

    // Scan counter, digit index and registered display outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_r  <= CNT_ZERO;
            digit_idx_r <= 2'd0;
            segments_r  <= SEG_BLANK;
            select_r    <= SEL_UNITS;
        end else begin
            scan_cnt_r  <= scan_next_s;
            digit_idx_r <= digit_next_s;
            segments_r  <= dec_seg_s;
            select_r    <= sel_s;
        end
    end

    assign value_ready    = ready_r;
    assign busy           = busy_r;
    assign segments       = segments_r;
    assign display_select = select_r;

endmodule
